key_round_scheduler: RTL and testbench

Downstream consumer of the per-half circular key shifter. It captures the shifted 64-bit key when the shifter's `status` goes high. It then iterates NUM_ROUNDS round keys, applying a DES-style per-round rotation schedule to the left and right 32-bit halves. Each round key is presented on a valid/ready interface to the round-function datapath.

---
 rtl/key_sched_pkg.sv | 11 +
 rtl/key_half_rotator.sv | 10 +
 rtl/key_round_scheduler.sv | 107 ++++++++++
 tb/tb_key_round_scheduler.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/key_sched_pkg.sv
// key_sched_pkg: shared state type, half width, rotation schedule and half-rotate helper
package key_sched_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  localparam int HALF_W = 32;
  function automatic logic [1:0] rot_amt(input int r, input int n);
    return (r == 0 || r == 1 || r == 8 || r == n - 1) ? 2'd1 : 2'd2;
  endfunction
  function automatic logic [HALF_W-1:0] rotl_half(input logic [HALF_W-1:0] half, input logic [1:0] amount);
    return amount == 2'd2 ? {half[HALF_W-3:0], half[HALF_W-1:HALF_W-2]} : {half[HALF_W-2:0], half[HALF_W-1]};
  endfunction
endpackage

// File: rtl/key_half_rotator.sv
// key_half_rotator: combinational rotate-left of one key half by 1 or 2
module key_half_rotator
  import key_sched_pkg::*;
(
  input  logic [HALF_W-1:0] din,
  input  logic [1:0]        amount,
  output logic [HALF_W-1:0] dout
);
  assign dout = rotl_half(din, amount);
endmodule

// File: rtl/key_round_scheduler.sv
// key_round_scheduler: captures a shifted key and streams NUM_ROUNDS DES-style round keys; optional rk_parity via KEY_ROUND_PARITY_EN
module key_round_scheduler
  import key_sched_pkg::*;
#(
  parameter int NUM_ROUNDS = 16,
  parameter int KEY_W      = 64
) (
  input  logic             clk,
  input  logic             set,
  input  logic [0:KEY_W-1] key_in,
  input  logic             key_valid,
  output logic [0:KEY_W-1] rk_out,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [3:0]       rk_round,
  output logic             busy,
  output logic             done
`ifdef KEY_ROUND_PARITY_EN
  ,
  output logic [0:7]       rk_parity
`endif
);
  state_t state_q, state_d;
  logic [HALF_W-1:0] c_q, c_d, d_q, d_d, c_src, d_src, c_rot, d_rot;
  logic [KEY_W-1:0] key_v;
  logic [1:0] amt;
  logic [3:0] round_q, round_d;
  logic valid_q, valid_d, done_q, done_d, armed_q, armed_d;
  logic accept, fire, last;
  assign key_v  = key_in;
  assign accept = state_q == IDLE && key_valid && armed_q;
  assign fire   = valid_q && rk_ready;
  assign last   = round_q == 4'(NUM_ROUNDS - 1);
  assign c_src  = accept ? key_v[KEY_W-1 -: HALF_W] : c_q;
  assign d_src  = accept ? key_v[HALF_W-1:0] : d_q;
  assign amt    = rot_amt(accept ? 0 : int'(round_q) + 1, NUM_ROUNDS);
  key_half_rotator u_rot_c (.din(c_src), .amount(amt), .dout(c_rot));
  key_half_rotator u_rot_d (.din(d_src), .amount(amt), .dout(d_rot));
  // next-state: capture on accept, advance on handshake, retire after the last round
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    valid_d = valid_q;
    round_d = round_q;
    done_d  = 1'b0;
    armed_d = !key_valid || (armed_q && !accept);
    if (accept) begin
      state_d = ACTIVE;
      c_d     = c_rot;
      d_d     = d_rot;
      valid_d = 1'b1;
      round_d = 4'd0;
    end else if (fire && !last) begin
      c_d     = c_rot;
      d_d     = d_rot;
      round_d = round_q + 4'd1;
    end else if (fire) begin
      valid_d = 1'b0;
      done_d  = 1'b1;
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // state and output registers; reset drops any in-flight round key
  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      valid_q <= 1'b0;
      round_q <= 4'd0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      round_q <= round_d;
      done_q  <= done_d;
      armed_q <= armed_d;
    end
  end
  assign rk_out   = {c_q, d_q};
  assign rk_valid = valid_q;
  assign rk_round = round_q;
  assign busy     = state_q == ACTIVE;
  assign done     = done_q;
`ifdef KEY_ROUND_PARITY_EN
  logic [KEY_W-1:0] next_key;
  logic [0:7] parity_q, parity_d;
  assign next_key = {c_d, d_d};
  // odd parity per byte, byte 0 being the most significant
  always_comb begin
    parity_d = '0;
    for (int i = 0; i < 8; i++) parity_d[i] = ~^next_key[KEY_W-1-8*i -: 8];
  end
  // parity tracks rk_out register-for-register
  always_ff @(posedge clk or posedge set) begin
    if (set) parity_q <= 8'hFF;
    else parity_q <= parity_d;
  end
  assign rk_parity = parity_q;
`endif
endmodule

// File: tb/tb_key_round_scheduler.sv
// tb_key_round_scheduler: directed and randomized checks against a schedule-level reference model
module tb_key_round_scheduler;
  localparam int N = 16;
  logic clk = 1'b0, set = 1'b1;
  logic [0:63] key_in = '0;
  logic key_valid = 1'b0, rk_ready = 1'b0;
  logic [0:63] rk_out;
  logic rk_valid, busy, done;
  logic [3:0] rk_round;
  int checks = 0, errors = 0;
  int mph = 0, mround = 0;
  bit marmed = 0, mvalid = 0, mdone = 0;
  logic [63:0] mkey = '0, held;

  always #5 clk = ~clk;

  key_round_scheduler #(.NUM_ROUNDS(N), .KEY_W(64)) dut (
    .clk(clk), .set(set), .key_in(key_in), .key_valid(key_valid),
    .rk_out(rk_out), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_round(rk_round), .busy(busy), .done(done)
  );

  function automatic logic [63:0] exp_rk(input logic [63:0] k, input int r);
    int cum = 0;
    logic [63:0] hi, lo;
    for (int i = 0; i <= r; i++) cum += (i == 0 || i == 1 || i == 8 || i == N - 1) ? 1 : 2;
    hi = {k[63:32], k[63:32]} << cum;
    lo = {k[31:0], k[31:0]} << cum;
    return {hi[63:32], lo[63:32]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rdy, input bit kv);
    bit acc, hs;
    rk_ready = rdy;
    key_valid = kv;
    acc = mph == 0 && kv && marmed;
    hs = mvalid && rdy;
    if (acc) begin
      mph = 1; mkey = key_in; mround = 0; mvalid = 1; mdone = 0;
    end else if (mph == 1 && hs) begin
      if (mround == N - 1) begin mvalid = 0; mdone = 1; mph = 2; end
      else mround++;
    end else if (mph == 2) begin
      mph = 0; mdone = 0;
    end
    if (!kv) marmed = 1;
    else if (acc) marmed = 0;
    @(posedge clk); #1;
    chk("rk_valid", 64'(rk_valid), 64'(mvalid));
    chk("rk_round", 64'(rk_round), 64'(mround));
    chk("done", 64'(done), 64'(mdone));
    chk("busy", 64'(busy), 64'(mph == 1));
    if (mvalid) chk("rk_out", rk_out, exp_rk(mkey, mround));
  endtask

  task automatic finish_seq();
    for (int i = 0; i < 200 && mph != 0; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
    checks++;
    assert (mph == 0) else begin
      errors++;
      $error("FAIL seq_timeout observed phase %0d expected 0", mph);
    end
  endtask

  task automatic model_reset();
    mph = 0; mround = 0; marmed = 0; mvalid = 0; mdone = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", rk_out, 64'h0);
    chk("rst_valid", 64'(rk_valid), 64'h0);
    chk("rst_round", 64'(rk_round), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    set = 1'b0;
    key_in = 64'h00000001_00000001;
    step(1, 0);
    step(1, 1);
    chk("t1_round0", rk_out, 64'h00000002_00000002);
    for (int i = 1; i < N; i++) begin
      step(1, 1);
      if (i == 1) chk("t1_round1", rk_out, 64'h00000004_00000004);
      if (i == 2) chk("t1_round2", rk_out, 64'h00000010_00000010);
      if (i == 15) chk("t1_round15", rk_out, 64'h10000000_10000000);
    end
    step(1, 1);
    chk("t1_done_pulse", 64'(done), 64'h1);
    repeat (5) step(1, 1);
    chk("t3_no_restart", 64'(rk_valid), 64'h0);
    key_in = 64'h0123_4567_89AB_CDEF;
    step(1, 0);
    step(0, 1);
    chk("t3_restart_round", 64'(rk_round), 64'h0);
    repeat (3) step(1, 1);
    held = rk_out;
    for (int i = 0; i < 5; i++) begin
      step(0, 1);
      chk("t2_hold_out", rk_out, held);
      chk("t2_hold_round", 64'(rk_round), 64'h3);
    end
    step(1, 1);
    chk("t2_release_round", 64'(rk_round), 64'h4);
    repeat (3) step(1, 1);
    #2 set = 1'b1;
    #1;
    chk("t4_async_out", rk_out, 64'h0);
    chk("t4_async_valid", 64'(rk_valid), 64'h0);
    chk("t4_async_round", 64'(rk_round), 64'h0);
    chk("t4_async_busy", 64'(busy), 64'h0);
    model_reset();
    @(negedge clk);
    set = 1'b0;
    repeat (3) step(1, 1);
    step(1, 0);
    step(1, 1);
    finish_seq();
    key_in = 64'h80000000_FFFFFFFF;
    step(1, 0);
    step(1, 1);
    chk("t5_wrap", rk_out, 64'h00000001_FFFFFFFF);
    finish_seq();
    for (int k = 0; k < 8; k++) begin
      key_in = {$urandom, $urandom};
      step($urandom_range(0, 1) != 0, 0);
      step($urandom_range(0, 1) != 0, 1);
      finish_seq();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
